// File: rtl/bm_pkg.sv
// Shared Box-Muller fixed-point package.
// Holds the stream formats (g: signed Q1.14, f: unsigned U4.13,
// x: signed Q5.11), the product-to-output shift and the sat_round helper
// shared by the BM stages.
package bm_pkg;

  localparam int BM_GW     = 16;  // g0/g1 width
  localparam int BM_G_FRAC = 14;
  localparam int BM_FW     = 17;  // f width
  localparam int BM_F_FRAC = 13;
  localparam int BM_OW     = 16;  // x0/x1 width
  localparam int BM_O_FRAC = 11;
  localparam int BM_SHIFT  = BM_G_FRAC + BM_F_FRAC - BM_O_FRAC;  // 27 -> 11 fractional bits
  localparam int BM_PW     = BM_GW + BM_FW + 1;                  // signed g * zero-extended f

  typedef struct packed {
    logic                    sat;
    logic signed [BM_OW-1:0] x;
  } sat_round_t;

  // Round half toward +inf, arithmetic shift, then clamp to the output range.
  // One guard bit keeps the rounding add from overflowing.
  function automatic sat_round_t sat_round(input logic signed [BM_PW-1:0] p,
                                           input int unsigned             shift);
    logic signed [BM_PW:0] r;
    logic signed [BM_PW:0] half;
    logic signed [BM_PW:0] max_v;
    logic signed [BM_PW:0] min_v;
    sat_round_t            res;
    half                   = (BM_PW + 1)'(1) << (shift - 1);
    r                      = {p[BM_PW-1], p} + half;
    r                      = r >>> shift;
    max_v                  = '0;
    max_v[BM_OW-2:0]       = '1;
    min_v                  = '1;
    min_v[BM_OW-2:0]       = '0;
    res.sat                = 1'b0;
    res.x                  = r[BM_OW-1:0];
    if (r > max_v) begin
      res.sat = 1'b1;
      res.x   = max_v[BM_OW-1:0];
    end else if (r < min_v) begin
      res.sat = 1'b1;
      res.x   = min_v[BM_OW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/bm_gauss_mult_if.sv
// Stream bundle for bm_gauss_mult: g pair input, f radius input,
// x pair output and the saturation counter.
// slave  : design side (accepts g/f, produces x)
// master : environment side
interface bm_gauss_mult_if
  import bm_pkg::*;
#(
  parameter int GW = BM_GW,
  parameter int FW = BM_FW,
  parameter int OW = BM_OW
);
  logic          g_valid;
  logic          g_ready;
  logic [GW-1:0] g0;
  logic [GW-1:0] g1;
  logic          f_valid;
  logic          f_ready;
  logic [FW-1:0] f;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] x0;
  logic [OW-1:0] x1;
  logic [15:0]   sat_cnt;

  modport slave (
    input  g_valid, g0, g1, f_valid, f, out_ready,
    output g_ready, f_ready, out_valid, x0, x1, sat_cnt
  );

  modport master (
    output g_valid, g0, g1, f_valid, f, out_ready,
    input  g_ready, f_ready, out_valid, x0, x1, sat_cnt
  );
endinterface

// File: rtl/bm_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// push/wdata : write when push (caller guarantees not full)
// pop/rdata  : rdata shows the head; pop removes it (caller guarantees not empty)
// count      : number of stored entries, 0..DEPTH
module bm_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/bm_gauss_mult.sv
// Final Box-Muller stage: pairs each radius f with the oldest queued
// (g0, g1) and emits x0 = f*g0, x1 = f*g1 rounded and saturated to Q5.11.
// clk, rst_n : clock, asynchronous active-low reset
// bus        : g stream in, f stream in, x stream out, sat_cnt
// Three-stage pipeline (register, multiply, round/saturate) that stalls as a
// whole while the output word is held.
module bm_gauss_mult
  import bm_pkg::*;
#(
  parameter int GW      = BM_GW,
  parameter int FW      = BM_FW,
  parameter int OW      = BM_OW,
  parameter int G_DEPTH = 8,
  parameter int SHIFT   = BM_SHIFT
) (
  input  logic           clk,
  input  logic           rst_n,
  bm_gauss_mult_if.slave bus
);
  localparam int PW = GW + FW + 1;
  localparam int CW = $clog2(G_DEPTH) + 1;

  logic [CW-1:0]       g_count;
  logic [2*GW-1:0]     g_head;
  logic                g_ready_i;
  logic                f_ready_i;
  logic                adv;
  logic                push;
  logic                fire;

  logic                v1;
  logic [FW-1:0]       f1;
  logic signed [GW-1:0] g0_1;
  logic signed [GW-1:0] g1_1;
  logic signed [FW:0]  f1_ext;

  logic                v2;
  logic signed [PW-1:0] p0;
  logic signed [PW-1:0] p1;

  sat_round_t          rd0;
  sat_round_t          rd1;

  logic                out_valid_q;
  logic [OW-1:0]       x0_q;
  logic [OW-1:0]       x1_q;
  logic [15:0]         sat_cnt_q;

  assign adv       = !out_valid_q || bus.out_ready;
  // No pass-through: a full FIFO refuses even when it pops this cycle.
  assign g_ready_i = g_count < CW'(G_DEPTH);
  assign f_ready_i = (g_count != '0) && adv;
  assign push      = bus.g_valid && g_ready_i;
  assign fire      = bus.f_valid && f_ready_i;

  bm_sync_fifo #(
    .WIDTH (2 * GW),
    .DEPTH (G_DEPTH)
  ) u_g_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({bus.g0, bus.g1}),
    .pop   (fire),
    .rdata (g_head),
    .count (g_count)
  );

  // S1: capture the paired operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      f1   <= '0;
      g0_1 <= '0;
      g1_1 <= '0;
    end else if (adv) begin
      v1           <= fire;
      f1           <= bus.f;
      {g0_1, g1_1} <= g_head;
    end
  end

  assign f1_ext = {1'b0, f1};

  // S2: signed g times zero-extended f, 27 fractional bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      p0 <= '0;
      p1 <= '0;
    end else if (adv) begin
      v2 <= v1;
      p0 <= PW'(g0_1) * PW'(f1_ext);
      p1 <= PW'(g1_1) * PW'(f1_ext);
    end
  end

  always_comb begin
    rd0 = sat_round(p0, SHIFT);
    rd1 = sat_round(p1, SHIFT);
  end

  // S3: x registers only move on a valid word, so idle cycles keep the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      sat_cnt_q   <= '0;
    end else if (adv) begin
      out_valid_q <= v2;
      if (v2) begin
        x0_q <= rd0.x;
        x1_q <= rd1.x;
        if ((rd0.sat || rd1.sat) && (sat_cnt_q != '1)) sat_cnt_q <= sat_cnt_q + 16'd1;
      end
    end
  end

  assign bus.g_ready   = g_ready_i;
  assign bus.f_ready   = f_ready_i;
  assign bus.out_valid = out_valid_q;
  assign bus.x0        = x0_q;
  assign bus.x1        = x1_q;
  assign bus.sat_cnt   = sat_cnt_q;
endmodule
